// File: rtl/gray_timer_ctrl.sv
// Sequencer for a cascade of 4-bit Gray counter stages: prescaled stage-0 enable,
// held clear, period counting with one-shot/periodic runs, irq pulse and done flag.
module gray_timer_ctrl #(
    parameter int NSTG = 2,
    parameter int PW   = 8,
    parameter int RW   = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          stop,
    input  logic          mode,
    input  logic [PW-1:0] presc,
    input  logic [RW-1:0] reps,
    input  logic          top_tc,
    output logic          ctr_cten,
    output logic          ctr_clr,
    output logic          busy,
    output logic          irq,
    output logic          done,
    output logic [RW-1:0] rep_cnt
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    // A chain with no stages can never wrap, so it never ends a period.
    localparam logic CHAIN_PRESENT = (NSTG > 0);

    state_t        state_reg, state_next;
    logic [PW-1:0] pcnt_reg, pcnt_next;
    logic [PW-1:0] presc_q_reg, presc_q_next;
    logic [RW-1:0] reps_q_reg, reps_q_next;
    logic          mode_q_reg, mode_q_next;
    logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
    logic          irq_reg, irq_next;
    logic          ctr_clr_reg;

    logic          tick;
    logic          period_end;
    logic          load;
    logic [RW-1:0] rep_inc;
    logic [RW-1:0] rep_sat;
    logic          last_period;

    assign tick        = (state_reg == RUN) && (pcnt_reg == presc_q_reg);
    assign period_end  = tick && top_tc && CHAIN_PRESENT;
    assign rep_inc     = rep_cnt_reg + RW'(1);
    assign rep_sat     = (&rep_cnt_reg) ? rep_cnt_reg : rep_inc;
    assign last_period = !mode_q_reg || ((reps_q_reg != '0) && (rep_inc == reps_q_reg));

    always_comb begin
        state_next   = state_reg;
        pcnt_next    = pcnt_reg;
        rep_cnt_next = rep_cnt_reg;
        irq_next     = 1'b0;
        load         = 1'b0;

        case (state_reg)
            IDLE: begin
                pcnt_next = '0;
                if (start && !stop) begin
                    load       = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                pcnt_next = '0;
                if (stop) begin
                    state_next = IDLE;
                end else if (start) begin
                    load = 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                    pcnt_next  = '0;
                end else if (start) begin
                    load       = 1'b1;
                    state_next = CLEAR;
                    pcnt_next  = '0;
                end else begin
                    pcnt_next = tick ? '0 : pcnt_reg + PW'(1);
                    if (period_end) begin
                        rep_cnt_next = rep_sat;
                        irq_next     = 1'b1;
                        if (last_period) begin
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                pcnt_next = '0;
                if (stop) begin
                    state_next = IDLE;
                end else if (start) begin
                    load       = 1'b1;
                    state_next = CLEAR;
                end
            end
            default: begin
                state_next = IDLE;
                pcnt_next  = '0;
            end
        endcase

        // An accepted start restarts the run from freshly sampled settings.
        if (load) begin
            rep_cnt_next = '0;
        end
    end

    assign presc_q_next = load ? presc : presc_q_reg;
    assign reps_q_next  = load ? reps  : reps_q_reg;
    assign mode_q_next  = load ? mode  : mode_q_reg;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg   <= IDLE;
            pcnt_reg    <= '0;
            presc_q_reg <= '0;
            reps_q_reg  <= '0;
            mode_q_reg  <= 1'b0;
            rep_cnt_reg <= '0;
            irq_reg     <= 1'b0;
            ctr_clr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pcnt_reg    <= pcnt_next;
            presc_q_reg <= presc_q_next;
            reps_q_reg  <= reps_q_next;
            mode_q_reg  <= mode_q_next;
            rep_cnt_reg <= rep_cnt_next;
            irq_reg     <= irq_next;
            // Registered from the next state so it equals the Moore decode without glitches.
            ctr_clr_reg <= (state_next == RUN) || (state_next == DONE);
        end
    end

    assign ctr_cten = tick;
    assign ctr_clr  = ctr_clr_reg;
    assign busy     = (state_reg == CLEAR) || (state_reg == RUN);
    assign done     = (state_reg == DONE);
    assign irq      = irq_reg;
    assign rep_cnt  = rep_cnt_reg;

endmodule

// File: tb/tb_gray_timer_ctrl.sv
// Bench for gray_timer_ctrl: models the stage chain and predicts every output from
// elapsed time since the accepted start, plus literal spot checks.
module tb_gray_timer_ctrl;

    localparam int NSTG  = 1;
    localparam int PW    = 8;
    localparam int RW    = 8;
    localparam int CHAIN = 16 ** NSTG;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mode = 1'b0;
    logic [PW-1:0] presc = '0;
    logic [RW-1:0] reps = '0;
    logic          top_tc;
    logic          tc_inject = 1'b0;
    logic          ctr_cten, ctr_clr, busy, irq, done;
    logic [RW-1:0] rep_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int irq_q[$];

    gray_timer_ctrl #(.NSTG(NSTG), .PW(PW), .RW(RW)) dut (
        .clk(clk), .clr(clr), .start(start), .stop(stop), .mode(mode),
        .presc(presc), .reps(reps), .top_tc(top_tc), .ctr_cten(ctr_cten),
        .ctr_clr(ctr_clr), .busy(busy), .irq(irq), .done(done), .rep_cnt(rep_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-stage chain position; tc on the tick that wraps 15 -> 0.
    logic [3:0] stg_pos;
    always @(posedge clk) begin
        if (!ctr_clr) stg_pos <= '0;
        else if (ctr_cten) stg_pos <= stg_pos + 4'd1;
    end
    assign top_tc = (ctr_cten && stg_pos == 4'hF) || tc_inject;

    // Run bookkeeping: when the run's CLEAR cycle was and what was latched.
    bit m_act = 1'b0;
    bit m_mode = 1'b0;
    int m_s = 0;
    int m_p = 1;
    int m_reps = 0;
    int m_hold = 0;

    // Expected {ctr_clr, ctr_cten, busy, irq, done, rep_cnt} for cycle n.
    function automatic logic [12:0] exp_at(input int n);
        bit e_clr, e_cten, e_busy, e_irq, e_done, fin;
        int e_rep, e, r, len, nper, lim;
        logic [7:0] rep8;
        e_clr = 0; e_cten = 0; e_busy = 0; e_irq = 0; e_done = 0;
        e_rep = m_hold;
        if (m_act) begin
            e = n - m_s;
            e_rep = 0;
            e_busy = 1;
            if (e > 0) begin
                r = e - 1;
                len = CHAIN * m_p;
                nper = r / len;
                lim = m_mode ? m_reps : 1;
                fin = (lim != 0) && (nper >= lim);
                e_clr = 1;
                e_busy = !fin;
                e_done = fin;
                e_cten = !fin && (r % m_p == m_p - 1);
                e_irq = (r > 0) && (r % len == 0) && (lim == 0 || nper <= lim);
                e_rep = fin ? lim : (nper > 255 ? 255 : nper);
            end
        end
        rep8 = e_rep[7:0];
        return {e_clr, e_cten, e_busy, e_irq, e_done, rep8};
    endfunction

    function automatic int exp_rep(input int n);
        logic [12:0] v;
        v = exp_at(n);
        return int'(v[7:0]);
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_act  <= 1'b0;
            m_hold <= 0;
        end else if (stop) begin
            if (m_act) begin
                m_hold <= exp_rep(cyc);
                m_act  <= 1'b0;
            end
        end else if (start) begin
            m_act  <= 1'b1;
            m_s    <= cyc + 1;
            m_mode <= mode;
            m_p    <= int'(presc) + 1;
            m_reps <= int'(reps);
        end
    end

    always @(negedge clk) begin : cmp
        logic [12:0] ex, got;
        ex  = exp_at(cyc);
        got = {ctr_clr, ctr_cten, busy, irq, done, rep_cnt};
        checks++;
        if (got !== ex) begin
            failures++;
            $display("FAIL cycle %0d outputs{clr,cten,busy,irq,done,rep}: got %b expected %b", cyc, got, ex);
        end
        if (clr && irq === 1'b1) irq_q.push_back(cyc - t0);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_rel(input int k);
        while (cyc - t0 < k) @(negedge clk);
    endtask

    task automatic pulse_start(input bit m, input int p, input int r);
        @(negedge clk);
        mode = m; presc = PW'(p); reps = RW'(r); start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_clr", ctr_clr, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_irq", irq, 0); chk("rst_rep", rep_cnt, 0); chk("rst_cten", ctr_cten, 0);
        clr = 1'b1;
        $display("reset released at cycle %0d", cyc);

        pulse_start(0, 0, 0);
        chk("t1_clear_clr", ctr_clr, 0); chk("t1_clear_busy", busy, 1);
        wait_rel(2);  chk("t1_cten_first", ctr_cten, 1);
        wait_rel(17); chk("t1_cten_last", ctr_cten, 1); chk("t1_top_tc", top_tc, 1);
        wait_rel(18); chk("t1_irq", irq, 1); chk("t1_done", done, 1); chk("t1_rep", rep_cnt, 1);
        wait_rel(19); chk("t1_irq_off", irq, 0); chk("t1_cten_off", ctr_cten, 0);
        tc_inject = 1'b1;
        wait_rel(22); tc_inject = 1'b0;
        chk("t1_done_hold", done, 1); chk("t1_rep_hold", rep_cnt, 1);
        pulse_stop();
        chk("t1_stop_busy", busy, 0); chk("t1_stop_done", done, 0); chk("t1_stop_rep", rep_cnt, 1);
        $display("one-shot presc=0 done, rep_cnt=%0d", rep_cnt);

        irq_q.delete();
        pulse_start(1, 3, 3);
        wait_rel(3); tc_inject = 1'b1;
        wait_rel(4); tc_inject = 1'b0;
        wait_rel(5); chk("t2_cten_tick", ctr_cten, 1);
        wait_rel(6); chk("t2_cten_gap", ctr_cten, 0);
        wait_rel(10); presc = 8'd0; reps = 8'd1; mode = 1'b0;
        wait_rel(260);
        chk("t2_irq_count", irq_q.size(), 3);
        if (irq_q.size() == 3) begin
            chk("t2_irq0", irq_q[0], 66); chk("t2_irq1", irq_q[1], 130); chk("t2_irq2", irq_q[2], 194);
        end
        chk("t2_rep", rep_cnt, 3); chk("t2_done", done, 1); chk("t2_cten", ctr_cten, 0);
        pulse_stop();
        $display("periodic presc=3 reps=3 done, irqs=%0d", irq_q.size());

        pulse_start(1, 0, 0);
        wait_rel(33); chk("t3_top_tc", top_tc, 1); stop = 1'b1;
        wait_rel(34); stop = 1'b0;
        chk("t3_irq", irq, 0); chk("t3_busy", busy, 0); chk("t3_clr", ctr_clr, 0); chk("t3_rep", rep_cnt, 1);
        $display("stop at period end, rep_cnt=%0d", rep_cnt);

        @(negedge clk);
        start = 1'b1; stop = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("t4_busy", busy, 0); chk("t4_clr", ctr_clr, 0);
        wait_rel(3); chk("t4_busy_later", busy, 0);
        $display("start+stop from idle stays idle");

        pulse_start(1, 0, 0);
        wait_rel(40); chk("t5_rep_before", rep_cnt, 2);
        pulse_start(0, 2, 0);
        chk("t5_busy", busy, 1); chk("t5_clr", ctr_clr, 0); chk("t5_rep", rep_cnt, 0);
        wait_rel(49); chk("t5_irq_early", irq, 0);
        wait_rel(50); chk("t5_irq", irq, 1); chk("t5_done", done, 1); chk("t5_rep_after", rep_cnt, 1);
        pulse_stop();
        $display("restart with presc=2 done");

        irq_q.delete();
        pulse_start(1, 0, 0);
        wait_rel(4820);
        chk("t6_rep_sat", rep_cnt, 255); chk("t6_busy", busy, 1); chk("t6_irq_count", irq_q.size(), 301);
        pulse_stop();
        $display("forever run, irqs=%0d", irq_q.size());

        pulse_start(1, 0, 0);
        wait_rel(30);
        @(posedge clk);
        #2 clr = 1'b0;
        #1;
        chk("t7_clr", ctr_clr, 0); chk("t7_busy", busy, 0); chk("t7_done", done, 0);
        chk("t7_irq", irq, 0); chk("t7_cten", ctr_cten, 0); chk("t7_rep", rep_cnt, 0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        repeat (5) @(negedge clk);
        chk("t7_idle", busy, 0);
        pulse_start(0, 0, 0);
        wait_rel(18); chk("t7_recover_irq", irq, 1);
        $display("async reset mid-run and recovery done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
